// File: rtl/btb_predictor_rv32i.sv
// Direct-mapped BTB with 2-bit counters for RV32I fetch.
// Optional stats counters: define BTB_STATS_EN.
module btb_predictor_rv32i #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] f_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [31:0] pred_pc_next,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_branch,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        ex_mispredict,
  output logic [31:0] ex_redirect_pc
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int ENTRIES = 2**IDX_W;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             upd;
  logic             br_miss;

  assign f_idx  = f_pc[IDX_W+1:2];
  assign f_tag  = f_pc[31:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[31:IDX_W+2];
  assign upd    = ex_valid && ex_is_branch;

  // Fetch-side lookup, zero latency, pre-edge contents only
  always_comb begin
    f_hit        = valid_q[f_idx] &&
                   (tag_q[f_idx] == f_tag);
    pred_taken   = f_hit && ctr_q[f_idx][1];
    pred_target  = f_hit ? target_q[f_idx] : 32'd0;
    pred_pc_next = pred_taken ? target_q[f_idx]
                              : f_pc + 32'd4;
  end

  // Resolution check and corrected PC for the EX stage
  always_comb begin
    br_miss = (ex_taken != ex_pred_taken) ||
              (ex_taken &&
               (ex_target != ex_pred_target));
    ex_mispredict = ex_valid &&
                    (ex_is_branch ? br_miss
                                  : ex_pred_taken);
    ex_redirect_pc = (ex_is_branch && ex_taken)
                   ? ex_target
                   : ex_pc + 32'd4;
  end

  // Next table contents from the resolved branch
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    ex_hit   = valid_q[ex_idx] &&
               (tag_q[ex_idx] == ex_tag);
    if (upd) begin
      if (ex_hit) begin
        if (ex_taken) begin
          target_d[ex_idx] = ex_target;
          if (ctr_q[ex_idx] != 2'd3)
            ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
        end else if (ctr_q[ex_idx] != 2'd0) begin
          ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
        end
      end else if (ex_taken) begin
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = ex_target;
        ctr_d[ex_idx]    = 2'b10;
      end
    end
  end

  // Table state; reset flushes and drops any update
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  // Saturating event counters
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (upd && (stat_br_q != 32'hFFFF_FFFF))
      stat_br_d = stat_br_q + 32'd1;
    if (ex_valid && ex_mispredict &&
        (stat_mp_q != 32'hFFFF_FFFF))
      stat_mp_d = stat_mp_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_btb_predictor_rv32i.sv
// Directed + random bench for btb_predictor_rv32i.
// Reference model is a plain per-set table.
module tb_btb_predictor_rv32i;

  logic        clock;
  logic        reset;
  logic [31:0] f_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] pred_pc_next;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_mispredict;
  logic [31:0] ex_redirect_pc;
`ifdef BTB_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int errors = 0;
  int checks = 0;

  btb_predictor_rv32i dut (
    .clock          (clock),
    .reset          (reset),
    .f_pc           (f_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pred_pc_next   (pred_pc_next),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_is_branch   (ex_is_branch),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .ex_mispredict  (ex_mispredict),
    .ex_redirect_pc (ex_redirect_pc)
`ifdef BTB_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  initial clock = 0;
  always #5 clock = ~clock;

  // Reference model: 16 sets, tag = pc >> 6
  bit          m_valid [16];
  int unsigned m_tag   [16];
  int unsigned m_tgt   [16];
  int          m_ctr   [16];
  longint      s_br;
  longint      s_mis;

  function automatic int unsigned idx_of(
    input logic [31:0] pc);
    return (pc >> 2) & 32'hF;
  endfunction

  function automatic bit m_hit(
    input logic [31:0] pc);
    int unsigned i;
    i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == (pc >> 6));
  endfunction

  function automatic bit m_ptaken(
    input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic bit m_mis();
    if (!ex_valid) return 0;
    if (!ex_is_branch) return ex_pred_taken;
    if (ex_taken != ex_pred_taken) return 1;
    return ex_taken && (ex_target != ex_pred_target);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_tgt[i]   = 0;
      m_ctr[i]   = 1;
    end
    s_br  = 0;
    s_mis = 0;
  endtask

  task automatic model_update();
    int unsigned i;
    i = idx_of(ex_pc);
    if (!(ex_valid && ex_is_branch)) return;
    if (m_hit(ex_pc)) begin
      if (ex_taken) begin
        m_tgt[i] = ex_target;
        if (m_ctr[i] < 3) m_ctr[i]++;
      end else if (m_ctr[i] > 0) begin
        m_ctr[i]--;
      end
    end else if (ex_taken) begin
      m_valid[i] = 1;
      m_tag[i]   = ex_pc >> 6;
      m_tgt[i]   = ex_target;
      m_ctr[i]   = 2;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h",
             tag, obs, exp);
    end
  endtask

  // Compare all combinational outputs to the model
  task automatic check_all(input string tag);
    bit          pt;
    logic [31:0] tg;
    pt = m_ptaken(f_pc);
    tg = m_hit(f_pc) ? m_tgt[idx_of(f_pc)] : 0;
    chk({tag, ".ptk"}, {31'd0, pred_taken},
        {31'd0, pt});
    chk({tag, ".ptg"}, pred_target, tg);
    chk({tag, ".pnx"}, pred_pc_next,
        pt ? m_tgt[idx_of(f_pc)] : f_pc + 4);
    chk({tag, ".mis"}, {31'd0, ex_mispredict},
        {31'd0, m_mis()});
    chk({tag, ".rdp"}, ex_redirect_pc,
        (ex_is_branch && ex_taken) ? ex_target
                                   : ex_pc + 4);
  endtask

  task automatic tick();
    bit mis;
    mis = m_mis();
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      if (ex_valid && ex_is_branch) s_br++;
      if (mis) s_mis++;
      model_update();
    end
    #1;
  endtask

  task automatic set_ex(input bit v,
                        input logic [31:0] pc,
                        input bit br, input bit tk,
                        input logic [31:0] tg,
                        input bit ptk,
                        input logic [31:0] ptg);
    ex_valid       = v;
    ex_pc          = pc;
    ex_is_branch   = br;
    ex_taken       = tk;
    ex_target      = tg;
    ex_pred_taken  = ptk;
    ex_pred_target = ptg;
    #1;
  endtask

  logic [31:0] pool [6];

  initial begin
    reset = 1;
    f_pc  = 0;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    tick();
    reset = 0;

    // Reset state
    f_pc = 32'h100;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    chk("rst.ptk", {31'd0, pred_taken}, 0);
    chk("rst.pnx", pred_pc_next, 32'h104);
    chk("rst.mis", {31'd0, ex_mispredict}, 0);

    // First taken resolution allocates
    set_ex(1, 32'h100, 1, 1, 32'h80, 0, 0);
    chk("alloc.mis", {31'd0, ex_mispredict}, 1);
    chk("alloc.rdp", ex_redirect_pc, 32'h80);
    check_all("alloc");
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    chk("hit.ptk", {31'd0, pred_taken}, 1);
    chk("hit.pnx", pred_pc_next, 32'h80);

    // Two not-taken: ctr 2 -> 1 -> 0
    set_ex(1, 32'h100, 1, 0, 32'h80, 1, 32'h80);
    check_all("nt1");
    tick();
    set_ex(1, 32'h100, 1, 0, 32'h80, 0, 32'h80);
    chk("nt2.mis", {31'd0, ex_mispredict}, 0);
    chk("nt2.rdp", ex_redirect_pc, 32'h104);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    chk("nt.ptk", {31'd0, pred_taken}, 0);

    // Four taken: ctr saturates at 3
    for (int k = 0; k < 4; k++) begin
      set_ex(1, 32'h100, 1, 1, 32'h80,
             m_ptaken(32'h100), 32'h80);
      check_all("sat");
      tick();
    end
    // Target change
    set_ex(1, 32'h100, 1, 1, 32'h90, 1, 32'h80);
    chk("tgt.mis", {31'd0, ex_mispredict}, 1);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    chk("tgt.ptg", pred_target, 32'h90);

    // Saturated at 3: one not-taken still predicts taken
    set_ex(1, 32'h100, 1, 0, 0, 1, 32'h90);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    chk("sat3.ptk", {31'd0, pred_taken}, 1);
    set_ex(1, 32'h100, 1, 1, 32'h90, 1, 32'h90);
    tick();

    // Alias: non-branch at 0x140 predicted taken
    set_ex(1, 32'h140, 0, 1, 32'h44, 1, 32'h90);
    chk("alias.mis", {31'd0, ex_mispredict}, 1);
    chk("alias.rdp", ex_redirect_pc, 32'h144);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    chk("alias.ptg", pred_target, 32'h90);
    f_pc = 32'h140;
    #1;
    chk("alias.miss", pred_target, 0);

    // Same-cycle update and lookup at 0x100
    f_pc = 32'h100;
    set_ex(1, 32'h100, 1, 1, 32'hA0, 1, 32'h90);
    chk("byp.old", pred_target, 32'h90);
    tick();
    chk("byp.new", pred_target, 32'hA0);

    // Reset during an update
    reset = 1;
    set_ex(1, 32'h200, 1, 1, 32'h300, 0, 0);
    tick();
    reset = 0;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    f_pc = 32'h200;
    #1;
    chk("rstu.ptk", {31'd0, pred_taken}, 0);
    chk("rstu.pnx", pred_pc_next, 32'h204);
    f_pc = 32'h100;
    #1;
    chk("rstu.old", pred_target, 0);

    // Wraparound
    f_pc = 32'hFFFF_FFFC;
    #1;
    chk("wrap.pnx", pred_pc_next, 0);

    // Randomised phase
    pool[0] = 32'h100;
    pool[1] = 32'h140;
    pool[2] = 32'h104;
    pool[3] = 32'h200;
    pool[4] = 32'h180;
    pool[5] = 32'hFFFF_FFFC;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] p, t, pt;
      bit          ptk;
      reset = ($urandom_range(0, 60) == 0);
      f_pc = pool[$urandom_range(0, 5)];
      p = pool[$urandom_range(0, 5)];
      t = {$urandom_range(0, 7), 4'h0};
      if ($urandom_range(0, 1) == 1) begin
        ptk = m_ptaken(p);
        pt  = m_hit(p) ? m_tgt[idx_of(p)] : 0;
      end else begin
        ptk = $urandom_range(0, 1);
        pt  = {$urandom_range(0, 7), 4'h0};
      end
      set_ex($urandom_range(0, 3) != 0, p,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 1), t, ptk, pt);
      check_all("rnd");
      tick();
    end
    reset = 0;

`ifdef BTB_STATS_EN
    set_ex(0, 0, 0, 0, 0, 0, 0);
    chk("st.br", stat_branches, s_br[31:0]);
    chk("st.mis", stat_mispredicts, s_mis[31:0]);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/btb_predictor_rv32i.md
Name: btb_predictor_rv32i

Overview:
- Fetch-side branch predictor: the predicting end of the branch-resolution path. Predicts next PC before the branch resolves; the existing brancher logic resolves it in EX.
- Direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Looked up combinationally with the fetch PC.
- Trained at the clock edge from the resolved outcome (cu_branch, taken, PC_branch).
- Flags mispredictions and supplies the corrected PC.

Parameters:
- IDX_W, 4: index width; ENTRIES = 2**IDX_W entries.
- TAG_W, 26: tag width; must equal 30 - IDX_W. The index is PC[IDX_W+1:2] and the tag is PC[31:IDX_W+2].

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- f_pc  in  32  fetch PC.
- pred_taken  out  1  prediction: taken.
- pred_target  out  32  BTB target of the hit entry; 0 on a miss.
- pred_pc_next  out  32  predicted next PC.
- ex_valid  in  1  EX-stage instruction valid.
- ex_pc  in  32  PC of the EX instruction.
- ex_is_branch  in  1  cu_branch of the EX instruction.
- ex_taken  in  1  resolved direction.
- ex_target  in  32  resolved taken target (PC + imm).
- ex_pred_taken  in  1  prediction made at fetch, carried down the pipe.
- ex_pred_target  in  32  predicted target, carried down the pipe.
- ex_mispredict  out  1  redirect required.
- ex_redirect_pc  out  32  corrected PC.

Behaviour:
- Storage per entry: valid (1), tag (TAG_W), target (32), ctr (2).
- Lookup (combinational, zero latency):
  - hit = valid[idx(f_pc)] && tag[idx(f_pc)] == tag(f_pc).
  - pred_taken = hit && ctr[1].
  - pred_target = hit ? target : 0.
  - pred_pc_next = pred_taken ? target : f_pc + 4. Addition is mod 2^32; 0xFFFFFFFC + 4 = 0x00000000.
- Update (rising clock edge) when ex_valid && ex_is_branch && !reset. Index and tag come from ex_pc.
  - Entry hit, ex_taken=1: ctr = min(ctr+1, 3); target = ex_target.
  - Entry hit, ex_taken=0: ctr = max(ctr-1, 0); target unchanged.
  - Entry miss, ex_taken=1: allocate/overwrite: valid=1, tag, target = ex_target, ctr = 2'b10.
  - Entry miss, ex_taken=0: no write.
- No write occurs when ex_valid=0 or ex_is_branch=0.
- ex_mispredict (combinational):
  - Requires ex_valid=1.
  - Branch case (ex_is_branch=1): asserted when ex_taken != ex_pred_taken, or when ex_taken && ex_target != ex_pred_target.
  - Non-branch case (ex_is_branch=0): asserted when ex_pred_taken=1 (alias hit); no table write.
- ex_redirect_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc + 4.
- Simultaneous lookup and update to the same index: the lookup sees the pre-edge contents. There is no write-through bypass.
- Reset (synchronous, highest priority):
  - All valid = 0, ctr = 2'b01, target = 0, tag = 0; any concurrent update is discarded.
  - After reset: pred_taken = 0 and pred_pc_next = f_pc + 4 for every f_pc.
- Reset asserted mid-stream flushes the table on that edge. Training resumes on the first edge with reset low.
- Outputs are purely combinational from state and inputs; no output register.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined:
  - Adds output ports stat_branches (32) and stat_mispredicts (32).
  - On each edge with ex_valid && ex_is_branch, stat_branches increments.
  - On each edge with ex_valid && ex_mispredict, stat_mispredicts increments.
  - Both saturate at 0xFFFFFFFF and are cleared to 0 by reset.
- Undefined: ports and counters absent; the rest of the behaviour is identical.

Test Plan:
- Reset, then f_pc=0x100 -> pred_taken=0, pred_pc_next=0x104; ex_valid=0 -> ex_mispredict=0.
- Branch at 0x100 taken to 0x80 (ex_pred_taken=0) -> ex_mispredict=1, ex_redirect_pc=0x80. Next cycle f_pc=0x100 -> pred_taken=1, pred_pc_next=0x80 (ctr=2).
- Same branch resolved not-taken twice -> ctr 2→1→0; f_pc=0x100 -> pred_taken=0. The second resolution with ex_pred_taken=0 -> ex_mispredict=0, ex_redirect_pc=0x104.
- Taken three times -> ctr saturates at 3; a fourth taken leaves ctr=3. Taken with ex_target=0x90 while ex_pred_target=0x80 -> ex_mispredict=1, stored target becomes 0x90.
- Aliasing (IDX_W=4): entry for 0x100 trained taken; ex_pc=0x140 is a non-branch with ex_pred_taken=1 -> ex_mispredict=1, ex_redirect_pc=0x144, table unchanged.
- Update and lookup at 0x100 in the same cycle -> lookup shows old value. Reset asserted during an update -> entry invalid afterwards. With BTB_STATS_EN defined, counts match the number of resolved branches and mispredicts.
